// File: rtl/mem_map_pkg.sv
// Shared types and constants for the on-chip 80186 memory controller.
//   region_e : which M10K-backed region a bus address falls into
//   state_e  : bus-side transfer FSM states
//   in_region: aligned-region hit test on a 20-bit byte address
package mem_map_pkg;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_RAM,
      REG_VRAM,
      REG_ROM
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE,
      HOLD
   } state_e;

   localparam logic [19:0] DEF_RAM_BASE  = 20'h00000;
   localparam logic [19:0] DEF_VRAM_BASE = 20'hB8000;
   localparam logic [19:0] DEF_ROM_BASE  = 20'hF0000;

   // Value returned when nothing legitimately drives the bus.
   localparam logic [15:0] BUS_FLOAT = 16'hFFFF;

   // Regions are size-aligned, so a hit is a match of every byte-address
   // bit above the region's word index plus A0.
   function automatic logic in_region(input logic [19:0] a,
                                      input logic [19:0] base,
                                      input int unsigned aw);
      return (a >> (aw + 1)) == (base >> (aw + 1));
   endfunction

endpackage

// File: rtl/bram_be_dp.sv
// 16-bit simple dual-port block RAM with byte enables, M10K-style.
//   clk, rst_n          : clock, async active-low reset (output registers only)
//   a_en_i              : port A access enable (read data register loads)
//   a_we_i, a_be_i[1:0] : port A write enable, byte enables {high, low}
//   a_addr_i, a_wdata_i : port A word address and write data
//   a_rdata_o           : port A registered read data (read-before-write)
//   b_addr_i, b_rdata_o : port B read-only, reads every cycle, registered
// INIT_FILE is handed to the FPGA tools as the array's initialisation file.
module bram_be_dp #(
   parameter int    AW        = 11,
   parameter string INIT_FILE = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_en_i,
   input  logic          a_we_i,
   input  logic [1:0]    a_be_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [15:0]   a_wdata_i,
   output logic [15:0]   a_rdata_o,
   input  logic [AW-1:0] b_addr_i,
   output logic [15:0]   b_rdata_o
);

   (* ram_init_file = INIT_FILE *) logic [15:0] mem_q [2**AW];

   logic [15:0] a_rdata_q;
   logic [15:0] b_rdata_q;

   always_ff @(posedge clk) begin
      if (a_we_i) begin
         if (a_be_i[0]) mem_q[a_addr_i][7:0]  <= a_wdata_i[7:0];
         if (a_be_i[1]) mem_q[a_addr_i][15:8] <= a_wdata_i[15:8];
      end
   end

   // Reads sample the array before this edge's write lands, so a same-word
   // collision on port B returns the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
         b_rdata_q <= mem_q[b_addr_i];
      end
   end

   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/mem_ctrl_onchip.sv
// On-chip memory controller for the 80186 bus: RAM, text VRAM and BIOS ROM
// in M10K, byte-lane handling, programmable wait states, READY handshake and
// a free-running registered VRAM read port for the VGA controller.
//   clk, rst_n       : clock, async active-low reset
//   addr, bhe_n      : bus byte address (addr[0] = A0), byte-high enable
//   rd, wr           : level strobes
//   wdata            : write data, lanes already in place
//   rdata, ready     : read data (held after the transfer), one-cycle ready
//   bus_err          : flags unmapped / invalid-lane / rd&wr with ready
//   vga_addr         : VGA word address into VRAM
//   vga_rdata        : VRAM word, one cycle after vga_addr
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for rd|wr; accepts request, commits writes, issues read
// WAIT  | wait-state countdown
// DONE  | ready=1 for one cycle, rdata/bus_err valid
// HOLD  | waiting for both strobes low before accepting a new request
module mem_ctrl_onchip
   import mem_map_pkg::*;
#(
   parameter int          RAM_AW      = 15,
   parameter logic [19:0] RAM_BASE    = DEF_RAM_BASE,
   parameter int          VRAM_AW     = 11,
   parameter logic [19:0] VRAM_BASE   = DEF_VRAM_BASE,
   parameter int          ROM_AW      = 15,
   parameter logic [19:0] ROM_BASE    = DEF_ROM_BASE,
   parameter string       ROM_INIT    = "bios.hex",
   parameter int          WAIT_STATES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [19:0]        addr,
   input  logic               bhe_n,
   input  logic               rd,
   input  logic               wr,
   input  logic [15:0]        wdata,
   output logic [15:0]        rdata,
   output logic               ready,
   output logic               bus_err,
   input  logic [VRAM_AW-1:0] vga_addr,
   output logic [15:0]        vga_rdata
);

   localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   region_e     region_q, region_d;
   logic        err_q, err_d;
   logic        is_wr_q, is_wr_d;
   logic [15:0] rdata_q, rdata_d;

   region_e     req_region;
   logic        req, lane_bad, req_err, issue, wr_ok;
   logic [1:0]  be;
   logic [15:0] done_data;

   logic        ram_en, ram_we, vram_en, vram_we, rom_en;
   logic [15:0] ram_rd, vram_rd, rom_rd;
   logic [15:0] ram_b_unused, rom_b_unused;

   always_comb begin
      req_region = REG_NONE;
      if (in_region(addr, RAM_BASE, RAM_AW))        req_region = REG_RAM;
      else if (in_region(addr, VRAM_BASE, VRAM_AW)) req_region = REG_VRAM;
      else if (in_region(addr, ROM_BASE, ROM_AW))   req_region = REG_ROM;
   end

   assign req      = rd | wr;
   assign lane_bad = bhe_n & addr[0];
   assign req_err  = (req_region == REG_NONE) | lane_bad | (rd & wr);
   assign be       = {~bhe_n, ~addr[0]};
   assign issue    = (state_q == IDLE) & req;
   // Write lands at the edge that ends the accepting cycle; gating with
   // rst_n keeps a reset during that cycle from committing anything.
   assign wr_ok    = issue & wr & ~req_err & rst_n;

   assign ram_en  = issue & (req_region == REG_RAM);
   assign ram_we  = wr_ok & (req_region == REG_RAM);
   assign vram_en = issue & (req_region == REG_VRAM);
   assign vram_we = wr_ok & (req_region == REG_VRAM);
   assign rom_en  = issue & (req_region == REG_ROM);

   bram_be_dp #(.AW(RAM_AW), .INIT_FILE("")) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_en_i    (ram_en),
      .a_we_i    (ram_we),
      .a_be_i    (be),
      .a_addr_i  (addr[RAM_AW:1]),
      .a_wdata_i (wdata),
      .a_rdata_o (ram_rd),
      .b_addr_i  ('0),
      .b_rdata_o (ram_b_unused)
   );

   bram_be_dp #(.AW(VRAM_AW), .INIT_FILE("")) u_vram (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_en_i    (vram_en),
      .a_we_i    (vram_we),
      .a_be_i    (be),
      .a_addr_i  (addr[VRAM_AW:1]),
      .a_wdata_i (wdata),
      .a_rdata_o (vram_rd),
      .b_addr_i  (vga_addr),
      .b_rdata_o (vga_rdata)
   );

   bram_be_dp #(.AW(ROM_AW), .INIT_FILE(ROM_INIT)) u_rom (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_en_i    (rom_en),
      .a_we_i    (1'b0),
      .a_be_i    (2'b00),
      .a_addr_i  (addr[ROM_AW:1]),
      .a_wdata_i (16'h0000),
      .a_rdata_o (rom_rd),
      .b_addr_i  ('0),
      .b_rdata_o (rom_b_unused)
   );

   always_comb begin
      done_data = BUS_FLOAT;
      if (err_q) begin
         done_data = BUS_FLOAT;
      end else if (is_wr_q) begin
         done_data = 16'h0000;
      end else begin
         case (region_q)
            REG_RAM:  done_data = ram_rd;
            REG_VRAM: done_data = vram_rd;
            REG_ROM:  done_data = rom_rd;
            default:  done_data = BUS_FLOAT;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      region_d = region_q;
      err_d    = err_q;
      is_wr_d  = is_wr_q;
      rdata_d  = rdata_q;
      ready    = 1'b0;
      bus_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               region_d = req_region;
               err_d    = req_err;
               is_wr_d  = wr;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WS_M1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE: begin
            ready   = 1'b1;
            bus_err = err_q;
            rdata_d = done_data;
            state_d = HOLD;
         end
         HOLD: begin
            if (!req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // During DONE the block RAM output is presented directly; rdata_q keeps
   // it afterwards so the value stays on the bus until the next transfer.
   assign rdata = (state_q == DONE) ? done_data : rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         region_q <= REG_NONE;
         err_q    <= 1'b0;
         is_wr_q  <= 1'b0;
         rdata_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         region_q <= region_d;
         err_q    <= err_d;
         is_wr_q  <= is_wr_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl_onchip.sv
module tb_mem_ctrl_onchip;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] addr;
   logic        bhe_n;
   logic        rd;
   logic        wr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ready;
   logic        bus_err;
   logic [10:0] vga_addr;
   logic [15:0] vga_rdata;

   mem_ctrl_onchip #(.ROM_INIT(""), .WAIT_STATES(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .bhe_n     (bhe_n),
      .rd        (rd),
      .wr        (wr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .bus_err   (bus_err),
      .vga_addr  (vga_addr),
      .vga_rdata (vga_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        err;
      logic        chk_d;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mdl[int];
   int          n_checks = 0;
   int          n_errors = 0;
   int          ready_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int region_of(input logic [19:0] a);
      if (a < 20'h10000) return 1;
      if (a >= 20'hB8000 && a < 20'hB9000) return 2;
      if (a >= 20'hF0000) return 3;
      return 0;
   endfunction

   function automatic int key_of(input logic [19:0] a);
      return int'(a[19:1]);
   endfunction

   always @(posedge clk) begin
      #1;
      if (ready === 1'b1) begin
         exp_t e;
         ready_cnt++;
         check_val("sb_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("bus_err", bus_err, e.err);
            if (e.chk_d) check_val("rdata", rdata, e.d);
         end
      end
   end

   task automatic xfer(input logic r, input logic w, input logic [19:0] a,
                       input logic b, input logic [15:0] d,
                       input int extra_hold, input bit early_drop);
      exp_t e;
      int   reg_id, n;
      logic [15:0] old;
      reg_id = region_of(a);
      e.err = (reg_id == 0) || (b && a[0]) || (r && w);
      e.chk_d = 1'b1;
      e.d = 16'hFFFF;
      if (!e.err && w) begin
         e.d = 16'h0000;
         if (reg_id == 1 || reg_id == 2) begin
            old = mdl.exists(key_of(a)) ? mdl[key_of(a)] : 16'h0000;
            if (!b)    old[15:8] = d[15:8];
            if (!a[0]) old[7:0]  = d[7:0];
            mdl[key_of(a)] = old;
         end
      end else if (!e.err) begin
         if (reg_id == 3 || !mdl.exists(key_of(a))) e.chk_d = 1'b0;
         else e.d = mdl[key_of(a)];
      end
      sb.push_back(e);
      @(negedge clk);
      rd = r; wr = w; addr = a; bhe_n = b; wdata = d;
      n = 0;
      while (1) begin
         @(posedge clk);
         #1;
         n++;
         if (ready === 1'b1) break;
         if (early_drop && n == 1) begin rd = 1'b0; wr = 1'b0; end
         if (n > 20) break;
      end
      if (n > 20) begin
         check_val("ready_timeout", 0, 1);
         void'(sb.pop_back());
      end else begin
         check_val("latency", 32'(n), 2);
      end
      repeat (extra_hold) @(negedge clk);
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int c0;
      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; bhe_n = 1'b0;
      wdata = '0; vga_addr = '0;
      #23;
      check_val("rst_ready", ready, 0);
      check_val("rst_bus_err", bus_err, 0);
      check_val("rst_rdata", rdata, 16'h0000);
      check_val("rst_vga", vga_rdata, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // word write / read
      xfer(0, 1, 20'h00100, 0, 16'hBEEF, 0, 0);
      xfer(1, 0, 20'h00100, 0, 16'h0000, 0, 0);

      // byte lanes
      xfer(0, 1, 20'h00200, 0, 16'h1234, 0, 0);
      xfer(0, 1, 20'h00201, 0, 16'hAB00, 0, 0);
      xfer(1, 0, 20'h00200, 0, 16'h0000, 0, 0);
      xfer(0, 1, 20'h00200, 1, 16'h00CD, 0, 0);
      xfer(1, 0, 20'h00200, 0, 16'h0000, 0, 0);

      // VRAM dual port
      xfer(0, 1, 20'hB8000, 0, 16'h0741, 0, 0);
      vga_addr = 11'd0;
      @(posedge clk); #1;
      check_val("vga_after_wr", vga_rdata, 16'h0741);
      xfer(1, 0, 20'hB8000, 0, 16'h0000, 0, 0);
      xfer(0, 1, 20'hB8002, 0, 16'h1111, 0, 0);
      vga_addr = 11'd1;
      fork
         xfer(0, 1, 20'hB8002, 0, 16'h2222, 0, 0);
         begin
            @(negedge clk);
            @(posedge clk); #1;
            check_val("vga_collide_old", vga_rdata, 16'h1111);
            @(posedge clk); #1;
            check_val("vga_collide_new", vga_rdata, 16'h2222);
         end
      join

      // ROM and unmapped
      xfer(1, 0, 20'hFFFF0, 0, 16'h0000, 0, 0);
      xfer(0, 1, 20'hFFFF0, 0, 16'h5555, 0, 0);
      xfer(1, 0, 20'h50000, 0, 16'h0000, 0, 0);
      xfer(0, 1, 20'h50000, 0, 16'h5555, 0, 0);

      // handshake: held strobe, then reissue
      c0 = ready_cnt;
      xfer(1, 0, 20'h00100, 0, 16'h0000, 10, 0);
      check_val("one_pulse_held", 32'(ready_cnt - c0), 1);
      c0 = ready_cnt;
      xfer(1, 0, 20'h00100, 0, 16'h0000, 0, 0);
      check_val("second_pulse", 32'(ready_cnt - c0), 1);

      // invalid lane, rd&wr, early strobe drop
      xfer(0, 1, 20'h00101, 1, 16'hFFFF, 0, 0);
      xfer(1, 0, 20'h00100, 0, 16'h0000, 0, 0);
      xfer(1, 1, 20'h00100, 0, 16'h0000, 0, 0);
      xfer(1, 0, 20'h00100, 0, 16'h0000, 0, 0);
      xfer(1, 0, 20'h00200, 0, 16'h0000, 0, 1);

      // reset during WAIT of a write: write already committed
      @(negedge clk);
      wr = 1'b1; addr = 20'h00300; bhe_n = 1'b0; wdata = 16'h5A5A;
      @(posedge clk); #1;
      check_val("pre_rst_rdata", rdata, 16'hABCD);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_ready", ready, 0);
      check_val("midrst_rdata", rdata, 16'h0000);
      check_val("midrst_bus_err", bus_err, 0);
      wr = 1'b0;
      mdl[key_of(20'h00300)] = 16'h5A5A;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(1, 0, 20'h00300, 0, 16'h0000, 0, 0);
      xfer(1, 0, 20'h00100, 0, 16'h0000, 0, 0);

      check_val("sb_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_onchip.md
Name: mem_ctrl_onchip

Overview:
- Parametrised on-chip memory controller for the 80186 system bus on the DE1-SoC.
- Decodes the 20-bit bus address into three regions, each backed by M10K: conventional RAM, text-mode VRAM and BIOS ROM.
- Applies 80186 byte-lane rules, inserts configurable wait states and drives a READY handshake to the BIU.
- Provides an independent registered VRAM read port for the VGA controller.

Parameters:
- RAM_AW, 15: RAM word-address width (2^15 words = 64 KB at RAM_BASE).
- RAM_BASE, 20'h00000: RAM base byte address; must be aligned to the region size.
- VRAM_AW, 11: VRAM word-address width (2 K words = 4 KB).
- VRAM_BASE, 20'hB8000: VRAM base byte address; aligned.
- ROM_AW, 15: ROM word-address width (64 KB).
- ROM_BASE, 20'hF0000: ROM base byte address; aligned.
- ROM_INIT, "bios.hex": ROM initialisation file.
- WAIT_STATES, 1: extra cycles inserted before ready (0..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- addr, input, 20: bus byte address; addr[0] is A0.
- bhe_n, input, 1: byte-high-enable, active low.
- rd, input, 1: read strobe, level, active high.
- wr, input, 1: write strobe, level, active high.
- wdata, input, 16: write data; high byte on [15:8], low byte on [7:0].
- rdata, output, 16: read data, held valid while ready=1.
- ready, output, 1: transfer complete.
- bus_err, output, 1: pulses with ready on an unmapped address, bhe_n=1 with a0=1, or rd and wr both high.
- vga_addr, input, VRAM_AW: VGA word address.
- vga_rdata, output, 16: VRAM word; 1-cycle registered latency.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0.
  - ready=0, bus_err=0, rdata=16'h0000, vga_rdata=16'h0000.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it. A write is either fully committed in the sample cycle or not committed at all.
- Decode: a region hit means addr[19:1] lies within [BASE, BASE + 2^AW words). Word index = addr offset >> 1. Regions never overlap.
- Byte lanes, evaluated on (bhe_n, a0):
  - (0,0): word access.
  - (0,1): high byte only.
  - (1,0): low byte only.
  - (1,1): invalid; no write, bus_err=1.
- FSM states: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - On (rd|wr), latch addr, bhe_n, wdata and the decoded region.
  - A write to a RAM or VRAM hit commits with the byte enables at the edge ending this cycle.
  - ROM writes are ignored. Unmapped writes are ignored and set bus_err.
  - For a read, issue the synchronous RAM read.
  - Go to WAIT if WAIT_STATES>0, else DONE.
- WAIT: counter counts WAIT_STATES-1 down to 0, then goes to DONE.
- DONE, lasting exactly one cycle:
  - ready=1.
  - rdata = region word for a read; 16'hFFFF for an unmapped, invalid-lane or rd&wr access; 16'h0000 for a write.
  - bus_err is valid.
  - Next state is HOLD.
- HOLD: ready=0, rdata held. Return to IDLE only when rd=0 and wr=0, so a held strobe is never double-issued.
- Latency: request seen in cycle T gives ready in cycle T+1+WAIT_STATES.
- Strobes dropped early (in WAIT) do not cancel the transfer: it completes and ready still pulses.
- VGA port:
  - Reads every cycle, independent of the FSM.
  - If a CPU write and a VGA read hit the same VRAM word in the same cycle, VGA returns the old data.
  - vga_addr is wrapped to VRAM_AW bits.

Decomposition:
- Shared package mem_map_pkg:
  - region_e enum: REG_NONE, REG_RAM, REG_VRAM, REG_ROM.
  - state_e enum: IDLE, WAIT, DONE, HOLD.
  - Default base-address constants.
  - Constant BUS_FLOAT=16'hFFFF.
- One sub-module, bram_be_dp:
  - Port A is read/write with 2-bit byte enable; port B is read-only.
  - Parameterised by address width and init file.
  - Instantiated for RAM, VRAM (port B drives VGA) and ROM (port A writes tied off).

Test Plan:
- Word write then read: wr addr=20'h00100 wdata=16'hBEEF (bhe_n=0), then rd 20'h00100 -> rdata=16'hBEEF; with WAIT_STATES=1, ready arrives 2 cycles after the strobe.
- High-byte write: preload 20'h00200=16'h1234; wr addr=20'h00201 bhe_n=0 wdata=16'hAB00 -> readback 16'hAB34. Low-byte write addr=20'h00200 bhe_n=1 wdata=16'h00CD -> readback 16'hABCD.
- VRAM dual port: CPU wr 20'hB8000=16'h0741; vga_addr=0 one cycle later -> vga_rdata=16'h0741 the following cycle. Same-cycle write and read -> old value.
- ROM and unmapped access: rd 20'hFFFF0 -> ROM_INIT word; wr to ROM -> content unchanged. rd 20'h50000 -> rdata=16'hFFFF with bus_err=1 in the same cycle as ready.
- Handshake: hold rd high for 10 cycles -> exactly one ready pulse. Drop rd, reassert -> second pulse. bhe_n=1 with a0=1 -> bus_err=1 and no write.
- Reset mid-WAIT: assert rst_n=0 -> ready=0 and rdata=0 immediately, state=IDLE. A write in progress is either fully committed or absent, never partial.
